// File: rtl/m_mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle control sequencer: state encodings,
// write-back / PC select constants and the latched instruction-type record.
package mc_pkg;

  typedef enum logic [2:0] {
    S_INIT = 3'd0,
    S_IF   = 3'd1,
    S_ID   = 3'd2,
    S_EX   = 3'd3,
    S_MA   = 3'd4,
    S_WB   = 3'd5,
    S_HALT = 3'd6
  } state_t;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_LD  = 2'd1;
  localparam logic [1:0] WB_NPC = 2'd2;

  localparam logic PC_NPC = 1'b0;
  localparam logic PC_TPC = 1'b1;

  typedef struct packed {
    logic r;
    logic i;
    logic s;
    logic b;
    logic u;
    logic j;
    logic ld;
  } itype_t;

endpackage

// File: rtl/m_mc_ctrl_wait_cnt.sv
// Memory wait counter: counts stalled cycles, cleared on every state change,
// flags timeout once the count equals WAIT_MAX.
module m_mc_wait_cnt #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  localparam logic [7:0] LIMIT = 8'(WAIT_MAX);

  logic [7:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en && cnt != LIMIT)
      cnt <= cnt + 8'd1;
  end

  assign timeout = (cnt == LIMIT);

endmodule

// File: rtl/m_mc_ctrl.sv
// Multi-cycle control sequencer (IF/ID/EX/MA/WB) for the RV32 subset datapath.
// Optional performance counters are enabled by defining MC_PERF_CNT_EN.
module m_mc_ctrl
  import mc_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15,
  parameter int unsigned HALT_REG = 30
) (
  input  logic       w_clk,
  input  logic       w_rst_n,
  input  logic       w_r,
  input  logic       w_i,
  input  logic       w_s,
  input  logic       w_b,
  input  logic       w_u,
  input  logic       w_j,
  input  logic       w_ld,
  input  logic [4:0] w_rd,
  input  logic       w_tkn,
  input  logic       w_imem_rdy,
  input  logic       w_dmem_rdy,
  output logic       w_imem_req,
  output logic       w_dmem_req,
  output logic       w_dmem_we,
  output logic       w_ir_we,
  output logic       w_pc_we,
  output logic       w_pc_sel,
  output logic       w_rf_we,
  output logic [1:0] w_wb_sel,
  output logic       w_alu_src,
  output logic [2:0] w_state,
  output logic       w_halt,
  output logic       w_err
`ifdef MC_PERF_CNT_EN
  ,
  output logic [31:0] w_cyc_cnt,
  output logic [31:0] w_ret_cnt
`else
  // default build: no performance counter ports
`endif
);

  localparam logic [4:0] HALT_RD = 5'(HALT_REG);

  state_t     state, state_nxt;
  itype_t     ty;
  logic [4:0] rd_q;
  logic       err_q, err_set;
  logic       wait_en, wait_clr, timeout;
  logic       unused_type;

  // I and U share the default EX/WB path, so their latched bits steer nothing.
  assign unused_type = ty.i ^ ty.u;

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n)
      state <= S_INIT;
    else
      state <= state_nxt;
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      ty   <= '0;
      rd_q <= '0;
    end else if (state == S_ID) begin
      ty   <= '{r: w_r, i: w_i, s: w_s, b: w_b, u: w_u, j: w_j, ld: w_ld};
      rd_q <= w_rd;
    end
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n)
      err_q <= 1'b0;
    else if (err_set)
      err_q <= 1'b1;
  end

  always_comb begin
    state_nxt  = state;
    err_set    = 1'b0;
    wait_en    = 1'b0;
    w_imem_req = 1'b0;
    w_dmem_req = 1'b0;
    w_dmem_we  = 1'b0;
    w_ir_we    = 1'b0;
    w_pc_we    = 1'b0;
    w_pc_sel   = PC_NPC;
    w_rf_we    = 1'b0;
    w_wb_sel   = WB_ALU;
    w_alu_src  = 1'b0;
    w_halt     = 1'b0;
    unique case (state)
      S_INIT: state_nxt = S_IF;
      S_IF: begin
        w_imem_req = 1'b1;
        if (w_imem_rdy) begin
          w_ir_we   = 1'b1;
          state_nxt = S_ID;
        end else if (timeout) begin
          err_set   = 1'b1;
          state_nxt = S_HALT;
        end else begin
          wait_en = 1'b1;
        end
      end
      S_ID: state_nxt = S_EX;
      S_EX: begin
        w_alu_src = !(ty.r | ty.b);
        if (ty.b) begin
          w_pc_we   = 1'b1;
          w_pc_sel  = w_tkn;
          state_nxt = S_IF;
        end else if (ty.s || ty.ld) begin
          state_nxt = S_MA;
        end else begin
          state_nxt = S_WB;
        end
      end
      S_MA: begin
        w_dmem_req = 1'b1;
        w_dmem_we  = ty.s;
        w_alu_src  = 1'b1;
        if (w_dmem_rdy) begin
          if (ty.s) begin
            w_pc_we   = 1'b1;
            w_pc_sel  = PC_NPC;
            state_nxt = S_IF;
          end else begin
            state_nxt = S_WB;
          end
        end else if (timeout) begin
          err_set   = 1'b1;
          state_nxt = S_HALT;
        end else begin
          wait_en = 1'b1;
        end
      end
      S_WB: begin
        w_rf_we   = 1'b1;
        w_pc_we   = 1'b1;
        w_pc_sel  = ty.j;
        w_wb_sel  = ty.j ? WB_NPC : (ty.ld ? WB_LD : WB_ALU);
        state_nxt = (rd_q == HALT_RD) ? S_HALT : S_IF;
      end
      S_HALT: w_halt = 1'b1;
      default: state_nxt = S_INIT;
    endcase
  end

  assign wait_clr = (state_nxt != state);

  m_mc_wait_cnt #(.WAIT_MAX(WAIT_MAX)) u_wait_cnt (
    .clk     (w_clk),
    .rst_n   (w_rst_n),
    .clr     (wait_clr),
    .en      (wait_en),
    .timeout (timeout)
  );

  assign w_state = state;
  assign w_err   = err_q;

`ifdef MC_PERF_CNT_EN
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      w_cyc_cnt <= '0;
      w_ret_cnt <= '0;
    end else begin
      if (state != S_INIT && state != S_HALT)
        w_cyc_cnt <= w_cyc_cnt + 32'd1;
      if (w_pc_we)
        w_ret_cnt <= w_ret_cnt + 32'd1;
    end
  end
`else
  // default build: counters absent
`endif

endmodule

// File: tb/tb_m_mc_ctrl.sv
// Scoreboard bench for m_mc_ctrl: the driver queues hand-computed per-cycle
// state/strobe vectors, a negedge monitor pops and compares them.
module tb_m_mc_ctrl;
  import mc_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       r = 0, i = 0, s = 0, b = 0, u = 0, j = 0, ld = 0;
  logic [4:0] rd = '0;
  logic       tkn = 0, imem_rdy = 0, dmem_rdy = 0;
  logic       imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, rf_we, alu_src;
  logic [1:0] wb_sel;
  logic [2:0] state;
  logic       halt, err;
`ifdef MC_PERF_CNT_EN
  logic [31:0] cyc_cnt, ret_cnt;
`endif

  always #5 clk = ~clk;

  m_mc_ctrl #(.WAIT_MAX(15), .HALT_REG(30)) dut (
    .w_clk(clk), .w_rst_n(rst_n),
    .w_r(r), .w_i(i), .w_s(s), .w_b(b), .w_u(u), .w_j(j), .w_ld(ld),
    .w_rd(rd), .w_tkn(tkn), .w_imem_rdy(imem_rdy), .w_dmem_rdy(dmem_rdy),
    .w_imem_req(imem_req), .w_dmem_req(dmem_req), .w_dmem_we(dmem_we),
    .w_ir_we(ir_we), .w_pc_we(pc_we), .w_pc_sel(pc_sel), .w_rf_we(rf_we),
    .w_wb_sel(wb_sel), .w_alu_src(alu_src), .w_state(state),
    .w_halt(halt), .w_err(err)
`ifdef MC_PERF_CNT_EN
    , .w_cyc_cnt(cyc_cnt), .w_ret_cnt(ret_cnt)
`endif
  );

  // strobe order: imem_req dmem_req dmem_we ir_we pc_we pc_sel rf_we wb_sel[1:0] alu_src
  localparam logic [9:0] SB_0   = 10'b0000000000;
  localparam logic [9:0] SB_IFW = 10'b1000000000;
  localparam logic [9:0] SB_IFR = 10'b1001000000;
  localparam logic [9:0] SB_IMM = 10'b0000000001;
  localparam logic [9:0] SB_BT  = 10'b0000110000;
  localparam logic [9:0] SB_BN  = 10'b0000100000;
  localparam logic [9:0] SB_LDM = 10'b0100000001;
  localparam logic [9:0] SB_STR = 10'b0110100001;
  localparam logic [9:0] SB_WBA = 10'b0000101000;
  localparam logic [9:0] SB_WBL = 10'b0000101010;
  localparam logic [9:0] SB_WBJ = 10'b0000111100;

  // type order: r i s b u j ld
  localparam logic [6:0] T_R  = 7'b1000000;
  localparam logic [6:0] T_I  = 7'b0100000;
  localparam logic [6:0] T_S  = 7'b0010000;
  localparam logic [6:0] T_B  = 7'b0001000;
  localparam logic [6:0] T_J  = 7'b0000010;
  localparam logic [6:0] T_LD = 7'b0100001;

  typedef struct {
    logic [14:0] v;
    int          id;
  } exp_t;

  exp_t q[$];
  exp_t e_mon;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   step_id = 0;

  task automatic cyc(input logic rst, input logic irdy, input logic drdy,
                     input logic tk, input logic [2:0] st, input logic [9:0] sb,
                     input logic hl = 1'b0, input logic er = 1'b0);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n    = rst;
    imem_rdy = irdy;
    dmem_rdy = drdy;
    tkn      = tk;
    e.v  = {st, hl, er, sb};
    e.id = step_id;
    step_id++;
    q.push_back(e);
  endtask

  task automatic ins(input logic [6:0] t, input logic [4:0] d);
    {r, i, s, b, u, j, ld} = t;
    rd = d;
  endtask

  task automatic fetch();
    cyc(1, 1, 0, 0, S_IF, SB_IFR);
    cyc(1, 0, 0, 0, S_ID, SB_0);
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      logic [14:0] act;
      e_mon = q.pop_front();
      act = {state, halt, err, imem_req, dmem_req, dmem_we, ir_we, pc_we,
             pc_sel, rf_we, wb_sel, alu_src};
      n_cmp++;
      if (act !== e_mon.v) begin
        n_bad++;
        $display("FAIL step%0d {state,halt,err,strobes} got=%b expected=%b",
                 e_mon.id, act, e_mon.v);
      end
    end
  end

  initial begin
    // reset held, then released
    cyc(0, 0, 0, 0, S_INIT, SB_0);
    cyc(1, 0, 0, 0, S_INIT, SB_0);

    // R-type rd=1
    ins(T_R, 5'd1);
    fetch();
    cyc(1, 0, 0, 0, S_EX, SB_0);
    cyc(1, 0, 0, 0, S_WB, SB_WBA);

    // branch taken, then not taken
    ins(T_B, 5'd0);
    fetch();
    cyc(1, 0, 0, 1, S_EX, SB_BT);
    fetch();
    cyc(1, 0, 0, 0, S_EX, SB_BN);

    // load with three stall cycles
    ins(T_LD, 5'd3);
    fetch();
    cyc(1, 0, 0, 0, S_EX, SB_IMM);
    repeat (3) cyc(1, 0, 0, 0, S_MA, SB_LDM);
    cyc(1, 0, 1, 0, S_MA, SB_LDM);
    cyc(1, 0, 0, 0, S_WB, SB_WBL);

    // store, zero wait
    ins(T_S, 5'd0);
    fetch();
    cyc(1, 0, 0, 0, S_EX, SB_IMM);
    cyc(1, 0, 1, 0, S_MA, SB_STR);

    // JAL rd=5
    ins(T_J, 5'd5);
    fetch();
    cyc(1, 0, 0, 0, S_EX, SB_IMM);
    cyc(1, 0, 0, 0, S_WB, SB_WBJ);

    // write-back to rd=30 halts; memories ready but ignored
    ins(T_I, 5'd30);
    fetch();
    cyc(1, 0, 0, 0, S_EX, SB_IMM);
    cyc(1, 0, 0, 0, S_WB, SB_WBA);
    repeat (20) cyc(1, 1, 1, 1, S_HALT, SB_0, 1'b1, 1'b0);

    // fetch timeout: 16 cycles in S_IF (count 0..15), then error halt
    cyc(0, 0, 0, 0, S_INIT, SB_0);
    cyc(1, 0, 0, 0, S_INIT, SB_0);
    repeat (16) cyc(1, 0, 0, 0, S_IF, SB_IFW);
    repeat (2) cyc(1, 0, 0, 0, S_HALT, SB_0, 1'b1, 1'b1);

    // ready arriving at count 15 wins
    cyc(0, 0, 0, 0, S_INIT, SB_0);
    cyc(1, 0, 0, 0, S_INIT, SB_0);
    ins(T_LD, 5'd2);
    repeat (15) cyc(1, 0, 0, 0, S_IF, SB_IFW);
    cyc(1, 1, 0, 0, S_IF, SB_IFR);
    cyc(1, 0, 0, 0, S_ID, SB_0);
    cyc(1, 0, 0, 0, S_EX, SB_IMM);
    cyc(1, 0, 0, 0, S_MA, SB_LDM);

    // reset pulsed mid memory access
    cyc(0, 0, 0, 0, S_INIT, SB_0);
    cyc(1, 0, 0, 0, S_INIT, SB_0);

    // three zero-wait ALU instructions
    ins(T_R, 5'd4);
    for (int k = 0; k < 3; k++) begin
      fetch();
      cyc(1, 0, 0, 0, S_EX, SB_0);
      cyc(1, 0, 0, 0, S_WB, SB_WBA);
    end
    cyc(1, 0, 0, 0, S_IF, SB_IFW);
`ifdef MC_PERF_CNT_EN
    n_cmp++;
    if (ret_cnt !== 32'd3) begin
      n_bad++;
      $display("FAIL ret_cnt got=%0d expected=3", ret_cnt);
    end
`endif

    repeat (2) @(posedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain got=%0d pending expected=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
